// File: rtl/tx_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_gen
// Description : Transceiver frame generator. Emits header, timestamp, FIFO
//               payload and trailer words, grouping frames in fours.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_gen #(
    parameter int          PAYLOAD_LEN = 125,
    parameter int          GAP_LEN     = 3,
    parameter logic [15:0] TS_INIT     = 16'd5
) (
    input  logic        tx_std_clkout,
    input  logic        rst_n,
    input  logic        tx_enable,
    input  logic [7:0]  src_usedw,
    input  logic [15:0] src_data,
    output logic        src_rd_req,
    output logic [15:0] TX_data,
    output logic [1:0]  tx_datak,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [7:0] c_USEDW_MIN = 8'(PAYLOAD_LEN);
    localparam logic [7:0] c_PAY_LAST  = 8'(PAYLOAD_LEN - 1);
    localparam logic [7:0] c_GAP_LAST  = 8'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam bit         c_HAS_GAP   = (GAP_LEN > 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GAP     = 3'd1,
        S_HDR     = 3'd2,
        S_TS      = 3'd3,
        S_PAYLOAD = 3'd4,
        S_TRAILER = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_ts;
    logic        w_start;
    logic [1:0]  w_idx_next;

    assign w_start    = tx_enable && (src_usedw >= c_USEDW_MIN);
    assign w_idx_next = r_idx + 2'd1;
    assign src_rd_req = (r_state == S_PAYLOAD);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start)
                    w_next = (r_idx == 2'd0 && c_HAS_GAP) ? S_GAP : S_HDR;
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST)
                    w_next = S_HDR;
            end
            S_HDR:     w_next = S_TS;
            S_TS:      w_next = S_PAYLOAD;
            S_PAYLOAD: begin
                if (r_cnt == c_PAY_LAST)
                    w_next = S_TRAILER;
            end
            S_TRAILER: begin
                // The start decision here already sees the advanced frame index.
                if (w_start)
                    w_next = (w_idx_next == 2'd0 && c_HAS_GAP) ? S_GAP : S_HDR;
                else
                    w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= 2'd0;
            r_ts    <= TS_INIT;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= 8'd0;
            else if (r_state == S_GAP || r_state == S_PAYLOAD)
                r_cnt <= r_cnt + 8'd1;
            if (r_state == S_TS)
                r_ts <= r_ts + 16'd1;
            if (r_state == S_TRAILER)
                r_idx <= w_idx_next;
        end
    end

    // Output words are registered, so they trail the state by one cycle.
    always_ff @(posedge tx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            TX_data    <= 16'hFFFF;
            tx_datak   <= 2'b00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_datak   <= 2'b00;
            busy       <= (r_state != S_IDLE);
            frame_done <= (r_state == S_TRAILER);
            case (r_state)
                S_HDR:     TX_data <= (r_idx == 2'd0) ? 16'hDEAD : 16'hBEEF;
                S_TS:      TX_data <= r_ts;
                S_PAYLOAD: TX_data <= src_data;
                S_TRAILER: TX_data <= 16'h7FFF;
                default:   TX_data <= 16'hFFFF;
            endcase
        end
    end

endmodule
`default_nettype wire
